// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out stream bundle for fir_mac_sequencer.
// The slave modport is the filter side and the master modport is the source/sink side.
interface fir_mac_sequencer_if #(
    parameter int DWIDTH = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_sat;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: a single signed MAC steps over TAPS coef/history pairs per sample.
// Optional macro FIR_SAT_EN clamps the result to DWIDTH bits and flags the clamp on m_sat.
module fir_mac_sequencer #(
    parameter int TAPS     = 20,
    parameter int DWIDTH   = 32,
    parameter int BIT_PREC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]  coef_wr_addr,
    input  logic [DWIDTH-1:0]        coef_wr_data,
    input  logic                     hist_clr,
    output logic                     busy,
    fir_mac_sequencer_if.slave       bus
);
    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = 2*DWIDTH + AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_r;
    logic signed [DWIDTH-1:0] coef_r [TAPS];
    logic signed [DWIDTH-1:0] hist_r [TAPS];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            hidx_r;
    logic [AW-1:0]            k_r;
    logic signed [ACCW-1:0]   acc_r;
    logic [DWIDTH-1:0]        m_data_r;
    logic                     m_valid_r;
    logic                     busy_r;

    logic                     s_ready_s;
    logic                     coef_addr_ok_s;
    logic signed [2*DWIDTH-1:0] prod_s;
    logic signed [ACCW-1:0]   acc_next_s;
    logic [DWIDTH-1:0]        out_data_s;

`ifdef FIR_SAT_EN
    logic                     m_sat_r;
    logic                     out_sat_s;
    logic signed [ACCW-1:0]   r_s;

    // True when v is representable as a signed DWIDTH-bit value.
    function automatic logic fits_dwidth(input logic signed [ACCW-1:0] v);
        return (&v[ACCW-1:DWIDTH-1]) || !(|v[ACCW-1:DWIDTH-1]);
    endfunction
`endif

    assign s_ready_s      = (state_r == ST_IDLE) && !coef_wr_en && !hist_clr;
    assign coef_addr_ok_s = (32'(coef_wr_addr) < TAPS);

    // MAC datapath and result formatting for the final tap.
    always_comb begin
        prod_s     = (2*DWIDTH)'(coef_r[k_r]) * (2*DWIDTH)'(hist_r[hidx_r]);
        acc_next_s = acc_r + ACCW'(prod_s);
`ifdef FIR_SAT_EN
        r_s = acc_next_s >>> BIT_PREC;
        if (fits_dwidth(r_s)) begin
            out_data_s = r_s[DWIDTH-1:0];
            out_sat_s  = 1'b0;
        end else begin
            out_data_s = r_s[ACCW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
            out_sat_s  = 1'b1;
        end
`else
        out_data_s = acc_next_s[BIT_PREC +: DWIDTH];
`endif
    end

    // Sequencer FSM with configuration, history ring and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= {DWIDTH{1'b0}};
                hist_r[i] <= {DWIDTH{1'b0}};
            end
            wr_ptr_r  <= {AW{1'b0}};
            hidx_r    <= {AW{1'b0}};
            k_r       <= {AW{1'b0}};
            acc_r     <= {ACCW{1'b0}};
            m_data_r  <= {DWIDTH{1'b0}};
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
`ifdef FIR_SAT_EN
            m_sat_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (coef_wr_en && coef_addr_ok_s) begin
                        coef_r[coef_wr_addr] <= coef_wr_data;
                    end
                    if (hist_clr) begin
                        for (int i = 0; i < TAPS; i++) begin
                            hist_r[i] <= {DWIDTH{1'b0}};
                        end
                        wr_ptr_r <= {AW{1'b0}};
                    end
                    if (bus.s_valid && s_ready_s) begin
                        hist_r[wr_ptr_r] <= bus.s_data;
                        hidx_r   <= wr_ptr_r;
                        wr_ptr_r <= (wr_ptr_r == AW'(TAPS-1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
                        acc_r    <= {ACCW{1'b0}};
                        k_r      <= {AW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_r  <= acc_next_s;
                    hidx_r <= (hidx_r == {AW{1'b0}}) ? AW'(TAPS-1) : hidx_r - AW'(1);
                    if (k_r == AW'(TAPS-1)) begin
                        m_data_r  <= out_data_s;
`ifdef FIR_SAT_EN
                        m_sat_r   <= out_sat_s;
`endif
                        m_valid_r <= 1'b1;
                        state_r   <= ST_OUT;
                    end else begin
                        k_r <= k_r + AW'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign busy        = busy_r;
`ifdef FIR_SAT_EN
    assign bus.m_sat   = m_sat_r;
`else
    assign bus.m_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: reset, impulse, latency/backpressure, config gating,
// ring wrap/clear, saturation (or wrap without FIR_SAT_EN) and mid-MAC reset.
module tb_fir_mac_sequencer;
    localparam int TAPS = 20;
    localparam int DW   = 32;
    localparam int AW   = $clog2(TAPS);
    localparam logic [DW-1:0] BIG = 32'h7FFF_FFFF;

    logic          clk;
    logic          rst_n;
    logic          coef_wr_en;
    logic [AW-1:0] coef_wr_addr;
    logic [DW-1:0] coef_wr_data;
    logic          hist_clr;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    fir_mac_sequencer_if #(.DWIDTH(DW)) bus ();

    fir_mac_sequencer #(.TAPS(TAPS), .DWIDTH(DW), .BIT_PREC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .hist_clr     (hist_clr),
        .busy         (busy),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(addr);
        coef_wr_data = data;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic clear_hist();
        @(negedge clk);
        hist_clr = 1'b1;
        @(posedge clk);
        #1;
        hist_clr = 1'b0;
    endtask

    task automatic load_ramp_coefs();
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'(16*(k+1)));
    endtask

    // Offers a sample and returns #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        n = 0;
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic recv(output logic [DW-1:0] d, output logic s);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("recv_timeout", 64'(n), 64'd0);
        d = bus.m_data;
        s = bus.m_sat;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [DW-1:0] din, input logic [DW-1:0] exp,
                       input logic exp_sat);
        logic [DW-1:0] d;
        logic          s;
        send(din);
        recv(d, s);
        chk(tag, 64'(d), 64'(exp));
        chk({tag, "_sat"}, 64'(s), 64'(exp_sat));
    endtask

    task automatic impulse(input string tag, input int nz);
        run(tag, 32'd16, 32'd16, 1'b0);
        for (int n = 1; n <= nz; n++) begin
            run(tag, 32'd0, (n < TAPS) ? DW'(16*(n+1)) : 32'd0, 1'b0);
        end
    endtask

    initial begin
        logic [DW-1:0]     d;
        logic              s;
        logic signed [127:0] e;
        int                lat;
        int                seen;

        rst_n        = 1'b0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = {AW{1'b0}};
        coef_wr_data = 32'd0;
        hist_clr     = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_data   = 32'd0;
        bus.m_ready  = 1'b1;

        // Reset state with a sample already offered.
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data",  64'(bus.m_data),  64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
        chk("rst_busy",    64'(busy),        64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_accept", 64'(busy), 64'd1);
        bus.s_valid = 1'b0;
        recv(d, s);
        chk("zero_coef_out", 64'(d), 64'd0);

        // Impulse response with ramp coefficients.
        load_ramp_coefs();
        impulse("impulse", 24);

        // Latency and backpressure.
        bus.m_ready = 1'b0;
        send(32'd16);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.m_valid && lat < 100);
        chk("latency", 64'(lat), 64'd20);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_m_data",  64'(bus.m_data),  64'd16);
            chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
            chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_m_valid", 64'(bus.m_valid), 64'd0);
        chk("hs_busy",    64'(busy),        64'd0);
        @(posedge clk);
        #1;
        chk("next_accept", 64'(busy), 64'd1);
        bus.s_valid = 1'b0;
        recv(d, s);
        chk("bp_next_out", 64'(d), 64'd32);

        // Coefficient write has priority over a pending sample.
        clear_hist();
        @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(0);
        coef_wr_data = 32'd32;
        bus.s_valid  = 1'b1;
        bus.s_data   = 32'd16;
        #1;
        chk("cfg_s_ready", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        chk("cfg_no_accept", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("cfg_then_accept", 64'(busy), 64'd1);
        bus.s_valid = 1'b0;
        recv(d, s);
        chk("cfg_new_coef", 64'(d), 64'd32);

        // Writes and clears during MAC are ignored; out-of-range address is ignored.
        write_coef(0, 32'd16);
        clear_hist();
        send(32'd16);
        repeat (3) @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(0);
        coef_wr_data = 32'd999;
        hist_clr     = 1'b1;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        hist_clr   = 1'b0;
        recv(d, s);
        chk("mac_wr_ignored", 64'(d), 64'd16);
        write_coef(20, 32'd12345);
        run("mac_clr_ignored", 32'd0, 32'd32, 1'b0);
        clear_hist();
        run("coef0_kept", 32'd16, 32'd16, 1'b0);

        // Ring wrap with flat coefficients, then clear and fresh impulse.
        for (int k = 0; k < TAPS; k++) write_coef(k, 32'd16);
        clear_hist();
        for (int n = 0; n < 45; n++) begin
            run("wrap_ramp", 32'd16, DW'(16*((n < TAPS) ? n+1 : TAPS)), 1'b0);
        end
        clear_hist();
        load_ramp_coefs();
        impulse("clr_impulse", 20);

        // Large coefficients and samples.
        for (int k = 0; k < TAPS; k++) write_coef(k, BIG);
        clear_hist();
        for (int n = 0; n < TAPS; n++) begin
`ifdef FIR_SAT_EN
            run("sat", BIG, BIG, 1'b1);
`else
            e = 128'(n+1) * 128'sd2147483647 * 128'sd2147483647;
            e = e >>> 4;
            run("wrap_big", BIG, e[31:0], 1'b0);
`endif
        end

        // Reset in the middle of MAC aborts without a result.
        load_ramp_coefs();
        send(32'd16);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.m_valid) seen = 1;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        load_ramp_coefs();
        impulse("midrst_impulse", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end
endmodule
